// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the 5-stage datapath and the hazard/stall controller.
// master = datapath (hazard sources), slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_en;
  logic        id_ex_flush;
  logic        ex_mem_en;
  logic [1:0]  state_o;
  logic        mem_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           ex_redirect, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           state_o, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           ex_redirect, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           state_o, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline enable/flush control: load-use bubbles, EX redirects, memory freeze
// and a memory-timeout watchdog. Define HAZARD_PERF_CNT_EN to add stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned WAIT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;

  logic freeze;
  logic rs1_hit;
  logic rs2_hit;
  logic lu_hazard;
  logic active;
  logic run_en;
  logic svc_redirect;
  logic svc_hazard;

  always_comb begin
    freeze    = hz.mem_req & ~hz.mem_ready;
    rs1_hit   = hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd);
    rs2_hit   = hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd);
    lu_hazard = hz.ex_mem_read & (hz.ex_rd != 5'd0) & (rs1_hit | rs2_hit);
  end

  // Priority: reset/HALT > freeze > redirect > load-use > free-running.
  always_comb begin
    active       = ~reset & (state != ST_HALT);
    run_en       = active & ~freeze;
    svc_redirect = run_en & hz.ex_redirect;
    svc_hazard   = run_en & ~hz.ex_redirect & lu_hazard;

    hz.pc_en       = run_en & ~svc_hazard;
    hz.if_id_en    = run_en & ~svc_hazard;
    hz.if_id_flush = svc_redirect;
    hz.id_ex_en    = run_en;
    hz.id_ex_flush = svc_redirect | svc_hazard;
    hz.ex_mem_en   = run_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (freeze) begin
            wait_cnt <= WAIT_ONE;
            // A timeout of one cycle halts straight from RUN.
            if (MEM_TIMEOUT == 1) begin
              state     <= ST_HALT;
              timeout_q <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (freeze) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
            if (wait_cnt == WAIT_LAST) begin
              state     <= ST_HALT;
              timeout_q <= 1'b1;
            end
          end else begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end
        end
        ST_HALT: begin
          if (!freeze) begin
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign hz.state_o     = reset ? 2'd0 : 2'(state);
  assign hz.mem_timeout = ~reset & timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((active & freeze) | svc_hazard) begin
        stall_q <= stall_q + 32'd1;
      end
      if (svc_redirect) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign hz.stall_cnt = reset ? '0 : stall_q;
  assign hz.flush_cnt = reset ? '0 : flush_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4); expected values come from a
// cycle model in the bench. Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int unsigned TMO = 4;

  logic clk;
  logic reset;
  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (TMO),
    .WAIT_W      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // bench-side reference state
  int unsigned m_st = 0;
  int unsigned m_wc = 0;
  logic        m_to = 1'b0;
  logic [31:0] m_sc = '0;
  logic [31:0] m_fc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic cyc(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                     input logic redir, input logic req, input logic rdy);
    logic fz, lu;
    exp_t e, g;
    @(negedge clk);
    reset          = rst;
    hz.id_rs1      = rs1;
    hz.id_rs2      = rs2;
    hz.id_use_rs1  = u1;
    hz.id_use_rs2  = u2;
    hz.ex_mem_read = mr;
    hz.ex_rd       = rd;
    hz.ex_redirect = redir;
    hz.mem_req     = req;
    hz.mem_ready   = rdy;

    fz = req & ~rdy;
    lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));

    if (rst) begin
      e = '0;
    end else begin
      if (m_st == 2 || fz) e.ctl = 6'b000000;
      else if (redir)      e.ctl = 6'b111111;
      else if (lu)         e.ctl = 6'b000111;
      else                 e.ctl = 6'b110101;
      e.st = 2'(m_st);
      e.to = m_to;
      e.sc = PERF ? m_sc : 32'd0;
      e.fc = PERF ? m_fc : 32'd0;
    end
    sb.push_back(e);

    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      check("ctl", {26'd0, hz.pc_en, hz.if_id_en, hz.if_id_flush,
                    hz.id_ex_en, hz.id_ex_flush, hz.ex_mem_en}, {26'd0, g.ctl});
      check("state_o", {30'd0, hz.state_o}, {30'd0, g.st});
      check("mem_timeout", {31'd0, hz.mem_timeout}, {31'd0, g.to});
      check("stall_cnt", hz.stall_cnt, g.sc);
      check("flush_cnt", hz.flush_cnt, g.fc);
    end

    @(posedge clk);
    if (rst) begin
      m_st = 0; m_wc = 0; m_to = 1'b0; m_sc = '0; m_fc = '0;
    end else begin
      if (m_st != 2) begin
        if (fz || (!redir && lu)) m_sc = m_sc + 32'd1;
        if (!fz && redir)         m_fc = m_fc + 32'd1;
      end
      case (m_st)
        0: if (fz) begin
             m_wc = 1;
             if (TMO == 1) begin m_st = 2; m_to = 1'b1; end
             else m_st = 1;
           end else m_wc = 0;
        1: if (fz) begin
             if (m_wc == TMO - 1) begin m_st = 2; m_to = 1'b1; end
             m_wc = m_wc + 1;
           end else begin
             m_st = 0; m_wc = 0;
           end
        default: ;
      endcase
    end
  endtask

  task automatic idle(input logic rst);
    cyc(rst, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic freeze_cyc(input logic redir);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, redir, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_rd = '0; hz.ex_redirect = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // load-use on rs1, then ex_rd=0, rs2 hazard, and rs2 match without use flag
    cyc(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);

    // redirect together with load-use hazard
    cyc(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    idle(1'b0);

    // memory wait of 3 cycles, then completion
    repeat (3) freeze_cyc(1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b0);

    // redirect held across a freeze, applied when memory completes
    repeat (2) freeze_cyc(1'b1);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    idle(1'b0);

    // ready in cycle N: no halt
    repeat (TMO - 1) freeze_cyc(1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b0);

    // N freeze cycles: halt, then everything stays off
    repeat (TMO) freeze_cyc(1'b0);
    idle(1'b0);
    cyc(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    freeze_cyc(1'b0);
    idle(1'b0);

    // reset recovery from HALT
    idle(1'b1);
    idle(1'b0);
    cyc(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);

    // reset mid-WAIT
    repeat (2) freeze_cyc(1'b0);
    idle(1'b1);
    idle(1'b0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 59) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
